// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU systolic-array controller.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_C,
        COMPUTE,
        READ,
        DONE
    } tpu_ctrl_state_t;

    localparam int TPU_DIM = 8;

    // Compute phase length: DIM operands plus 2*(DIM-1) skew fill/drain cycles.
    function automatic int tpu_step_count(input int dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/tpu_phase_cnt.sv
// Loadable up-counter with enable, synchronous clear and terminal-count flag.
module tpu_phase_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= count + W'(1);
    end

    assign tc = (count == last);

endmodule

// File: rtl/tpu_array_ctrl.sv
// Job sequencer for a DIM x DIM systolic array: LOAD_C -> COMPUTE -> READ -> DONE.
// Optional TPU_CTRL_PERF_EN adds saturating busy/stall performance counters.
module tpu_array_ctrl
    import tpu_pkg::*;
#(
    parameter int DIM    = TPU_DIM,
    parameter int STEP_W = $clog2(3 * DIM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clear_c,
    input  logic                    stall,
    output logic                    busy,
    output logic                    done,
    output logic                    mac_en,
    output logic [DIM-1:0]          c_wren,
    output logic                    c_zero,
    output logic [$clog2(DIM)-1:0]  row_idx,
    output logic [STEP_W-1:0]       step,
    output logic                    c_out_valid
`ifdef TPU_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_busy_cycles,
    output logic [31:0]             perf_stall_cycles
`endif
);

    localparam int ROW_W = $clog2(DIM);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(DIM - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(tpu_step_count(DIM) - 1);

    tpu_ctrl_state_t    state;
    logic               clr_q;
    logic [ROW_W-1:0]   row_cnt;
    logic [STEP_W-1:0]  step_cnt;
    logic               row_tc;
    logic               step_tc;
    logic               row_phase;
    logic               active;
    logic               row_en;
    logic               step_en;

    assign row_phase = (state == LOAD_C) || (state == READ);
    assign active    = row_phase || (state == COMPUTE);
    assign row_en    = row_phase && !stall;
    assign step_en   = (state == COMPUTE) && !stall;

    // Counters return to zero on phase exit so the next phase always starts at 0.
    tpu_phase_cnt #(.W(ROW_W)) u_row_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (row_en && row_tc),
        .load     (1'b0),
        .load_val ('0),
        .en       (row_en),
        .last     (ROW_LAST),
        .count    (row_cnt),
        .tc       (row_tc)
    );

    tpu_phase_cnt #(.W(STEP_W)) u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (step_en && step_tc),
        .load     (1'b0),
        .load_val ('0),
        .en       (step_en),
        .last     (STEP_LAST),
        .count    (step_cnt),
        .tc       (step_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            clr_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        clr_q <= clear_c;
                        state <= LOAD_C;
                    end
                end
                LOAD_C:  if (row_en && row_tc)   state <= COMPUTE;
                COMPUTE: if (step_en && step_tc) state <= READ;
                READ:    if (row_en && row_tc)   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stall gates the strobes combinationally; everything else decodes registered state.
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign mac_en      = step_en;
    assign c_wren      = ((state == LOAD_C) && !stall) ? (DIM'(1) << row_cnt) : '0;
    assign c_zero      = (state == LOAD_C) && clr_q;
    assign row_idx     = row_phase ? row_cnt : '0;
    assign step        = (state == COMPUTE) ? step_cnt : '0;
    assign c_out_valid = (state == READ) && !stall;

`ifdef TPU_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && (perf_busy_cycles != '1))
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (active && stall && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    // Without the perf option the controller carries no extra state.
`endif

endmodule

// File: doc/tpu_array_ctrl.md
# tpu_array_ctrl

Sequencer for a DIM×DIM systolic array of tpumac cells. It runs one matrix-multiply job per `start`:
- load or clear the accumulator (C) rows through the cells' write-enable path,
- stream skewed A/B operands with the array-wide MAC enable,
- step the result rows out to the host-side capture logic.

It sits between the job-issue front end and the array, and owns the array's `en`/`WrEn` control wires.

## Interface
Parameters:
- DIM, 8, array dimension (rows = columns = DIM); DIM ≥ 2
- STEP_W, $clog2(3*DIM), width of the compute-step index

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; accepted only in IDLE
- clear_c  in  1  sampled with accepted `start`; 1 = zero accumulators, 0 = load C from memory
- stall  in  1  operand/result memory not ready; freezes the active phase
- busy  out  1  high from the cycle after accept through DONE
- done  out  1  one-cycle pulse in DONE
- mac_en  out  1  `en` to every cell
- c_wren  out  DIM  one-hot per-row `WrEn`
- c_zero  out  1  steers Cin mux to zero during LOAD_C
- row_idx  out  $clog2(DIM)  current row in LOAD_C/READ
- step  out  STEP_W  compute-step index for the A/B skew feeders
- c_out_valid  out  1  row `row_idx` Cout is valid for capture

Reset: every output is 0 and the state is IDLE. This is asynchronous and active-high: one clock, `clk`, with asynchronous active-high reset `rst`.

## Operation
States: IDLE → LOAD_C → COMPUTE → READ → DONE → IDLE.

- **IDLE**
  - All outputs 0.
  - `start`=1 latches `clear_c` into `clr_q`; next state is LOAD_C with row counter 0.
  - `stall` is ignored in IDLE.
- **LOAD_C**
  - `c_wren` = one-hot(row), `row_idx` = row, `c_zero` = `clr_q`.
  - Row increments each non-stalled cycle.
  - After row DIM-1 the next state is COMPUTE with step 0.
- **COMPUTE**
  - `mac_en` = 1 and `step` = current step.
  - Step increments each non-stalled cycle over 0 … 3·DIM-3, i.e. 3·DIM-2 active cycles: DIM operands plus 2·(DIM-1) skew fill/drain.
  - After the last step the next state is READ with row 0.
- **READ**
  - `c_out_valid` = 1 and `row_idx` = row.
  - Row increments each non-stalled cycle; after row DIM-1 the next state is DONE.
- **DONE**
  - `done` = 1 for one cycle, `busy` = 1; next state is IDLE.
- **Stall** (LOAD_C, COMPUTE, READ only):
  - `mac_en`, `c_wren` and `c_out_valid` are forced 0.
  - Counters and state hold; `row_idx`/`step` hold their values.
  - Stall is sampled combinationally in the same cycle; there is no stall latency.
- `c_wren` and `mac_en` are never high together. This holds the cell priority (`en` over `WrEn`) out of play.
- `start` while busy is ignored; there is no queueing.
- Counters wrap only by explicit reset to 0 on phase exit; no counter ever exceeds its phase limit.

## Timing
- `start` accepted at cycle t:
  - LOAD_C occupies t+1 … t+DIM
  - COMPUTE occupies t+DIM+1 … t+4·DIM-2
  - READ occupies t+4·DIM-1 … t+5·DIM-2
  - DONE at t+5·DIM-1
- Each stalled cycle delays every later event by exactly 1.
- `start` in the DONE cycle is ignored. Earliest re-accept is the cycle after DONE.
- `rst` mid-job:
  - immediate return to IDLE with all outputs 0
  - no `done` pulse
  - `clr_q` cleared
- All outputs are registered-state decodes. There is no combinational path from `start` to outputs; the `stall` path is the only combinational input-to-output path.

## Configuration
- TPU_CTRL_PERF_EN defined:
  - adds outputs `perf_busy_cycles` (32 bit) and `perf_stall_cycles` (32 bit).
  - Both clear on `rst` and on accepted `start`.
  - `perf_busy_cycles` counts cycles with `busy`=1.
  - `perf_stall_cycles` counts `busy` cycles with `stall`=1 in an active phase.
  - Both saturate at all-ones and hold after DONE until the next start.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `tpu_pkg` holds:
  - the state enum `tpu_ctrl_state_t` (IDLE, LOAD_C, COMPUTE, READ, DONE)
  - the default DIM constant
  - the step-count function (3·DIM-2)
- One sub-module, `tpu_phase_cnt`: a loadable up-counter with enable, terminal-count flag and clear. It is instantiated once for the row count and once for the step count.

## Test plan
- DIM=8, `clear_c`=0, `start` at cycle 0, no stall:
  - `c_wren` = 0x01 … 0x80 on cycles 1–8
  - `mac_en` high on cycles 9–30 with `step` 0–21
  - `c_out_valid` on cycles 31–38
  - `done` on cycle 39 only
- `clear_c`=1: `c_zero`=1 exactly during cycles 1–8; otherwise the first bench's trace is identical.
- Stall for 3 cycles at step 5:
  - `mac_en`=0 and `step` stuck at 5 for 3 cycles
  - `done` moves to cycle 42
- `start` pulsed during COMPUTE and in DONE: ignored, with no second job. A `start` on cycle 40 is accepted.
- `rst` asserted at cycle 12:
  - all outputs 0 the same cycle
  - no `done`
  - a new `start` afterwards runs the full 40-cycle job
- TPU_CTRL_PERF_EN build running the stall scenario: `perf_busy_cycles`=42 and `perf_stall_cycles`=3 after DONE.
